// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, round constants, FSM states and GF(2^8) doubling.
package aes_pkg;

   localparam int AES_NR = 10;

   localparam logic [7:0] AES_RCON [AES_NR] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      DONE
   } aes_state_e;

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: one byte in, one byte out, purely combinational table lookup.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   // Entry n lives at bits [8n +: 8]; row k of the literal holds entries 16k..16k+15.
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign y = SBOX[{a, 3'b000} +: 8];

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock, key schedule expanded on the fly.
// Define AES_ENC_LAST_KEY_OUT_EN to expose the round-10 key on last_key.
module aes_encrypt_iter
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] plaintext,
   input  logic [0:127] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] ciphertext
`ifdef AES_ENC_LAST_KEY_OUT_EN
   ,
   output logic [0:127] last_key
`endif
);

   localparam logic [3:0] LAST_RND = 4'(AES_NR);

   aes_state_e   fsm_q, fsm_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [127:0] state_q, state_d;
   logic [127:0] key_q, key_d;

   logic [7:0]   sb_out [16];
   logic [7:0]   sr [16];
   logic [7:0]   mc [16];
   logic [31:0]  rot_w3, sub_w3;
   logic [31:0]  w0n, w1n, w2n, w3n;
   logic [7:0]   rcon;
   logic [127:0] rk, round_out;

   // Byte i of a block sits at [127-8*i -: 8]: column-major, byte 0 in the top bits.
   for (genvar i = 0; i < 16; i++) begin : g_subbytes
      aes_sbox u_sbox (.a(state_q[127-8*i -: 8]), .y(sb_out[i]));
   end

   assign rot_w3 = {key_q[23:0], key_q[31:24]};
   for (genvar j = 0; j < 4; j++) begin : g_subword
      aes_sbox u_sbox (.a(rot_w3[31-8*j -: 8]), .y(sub_w3[31-8*j -: 8]));
   end

   always_comb begin
      rcon = 8'h00;
      for (int i = 0; i < AES_NR; i++)
         if (rnd_q == 4'(i + 1)) rcon = AES_RCON[i];
   end

   assign w0n = key_q[127:96] ^ sub_w3 ^ {rcon, 24'h000000};
   assign w1n = key_q[95:64]  ^ w0n;
   assign w2n = key_q[63:32]  ^ w1n;
   assign w3n = key_q[31:0]   ^ w2n;
   assign rk  = {w0n, w1n, w2n, w3n};

   // ShiftRows, MixColumns (skipped in the final round) and AddRoundKey.
   always_comb begin
      round_out = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[4*c+r] = sb_out[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
         mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
         mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
      end
      for (int i = 0; i < 16; i++)
         round_out[127-8*i -: 8] = ((rnd_q == LAST_RND) ? sr[i] : mc[i]) ^ rk[127-8*i -: 8];
   end

   // NOTE: every next-state value and output gets a default first, so no latch is inferred.
   always_comb begin
      fsm_d      = fsm_q;
      rnd_d      = rnd_q;
      state_d    = state_q;
      key_d      = key_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      ciphertext = '0;
      case (fsm_q)
         IDLE: begin
            in_ready = !reset;
            if (in_valid) begin
               state_d = plaintext ^ key;
               key_d   = key;
               rnd_d   = 4'd1;
               fsm_d   = ROUND;
            end
         end
         ROUND: begin
            state_d = round_out;
            key_d   = rk;
            if (rnd_q == LAST_RND) fsm_d = DONE;
            else                   rnd_d = rnd_q + 4'd1;
         end
         DONE: begin
            out_valid  = 1'b1;
            ciphertext = state_q;
            if (out_ready) begin
               fsm_d = IDLE;
               rnd_d = '0;
            end
         end
         default: fsm_d = IDLE;
      endcase
      // A round counter outside 1..10 while busy means corrupted state: abandon the block.
      if (fsm_q == ROUND && (rnd_q == 4'd0 || rnd_q > LAST_RND)) begin
         fsm_d = IDLE;
         rnd_d = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the block and key registers are cleared too, so nothing from an aborted block survives reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q   <= IDLE;
         rnd_q   <= '0;
         state_q <= '0;
         key_q   <= '0;
      end else begin
         fsm_q   <= fsm_d;
         rnd_q   <= rnd_d;
         state_q <= state_d;
         key_q   <= key_d;
      end
   end

`ifdef AES_ENC_LAST_KEY_OUT_EN
   assign last_key = (fsm_q == DONE) ? key_q : '0;
`endif

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: FIPS-197 vectors, backpressure, busy input, reset, back-to-back.
// Build with AES_ENC_LAST_KEY_OUT_EN defined to also check last_key.
module tb_aes_encrypt_iter;

   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] LK_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] LK_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic         clk       = 1'b0;
   logic         reset     = 1'b1;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b0;
   logic [0:127] plaintext = '0;
   logic [0:127] key       = '0;
   logic         in_ready;
   logic         out_valid;
   logic [0:127] ciphertext;
`ifdef AES_ENC_LAST_KEY_OUT_EN
   logic [0:127] last_key;
`endif

   aes_encrypt_iter dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .key        (key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ciphertext (ciphertext)
`ifdef AES_ENC_LAST_KEY_OUT_EN
      ,
      .last_key   (last_key)
`endif
   );

   always #5 clk = ~clk;

   int n_pass   = 0;
   int n_total  = 0;
   int edge_cnt = 0;
   always @(posedge clk) edge_cnt++;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   // ---------------- reference model (FIPS-197, byte-array form) ----------------
   logic [7:0] sb [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d = {b, b};
      return d[15-n -: 8];
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] k,
                                              output logic [127:0] lk);
      logic [31:0]  w [44];
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [7:0]   rc = 8'h01;
      logic [31:0]  tmp;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = sb[s[r][(c+r)%4]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               if (rd < 10)
                  s[r][c] = gmul(t[r][c], 8'h02) ^ gmul(t[(r+1)%4][c], 8'h03)
                            ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
               else
                  s[r][c] = t[r][c];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[r][c] ^= w[4*rd+c][31-8*r -: 8];
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            res[127-8*(4*c+r) -: 8] = s[r][c];
      lk = {w[40], w[41], w[42], w[43]};
      return res;
   endfunction

   // ---------------- per-cycle compare against a transaction timeline ----------------
   // A block accepted at the edge after negedge k is expected to show out_valid from negedge k+11
   // (accept cycle plus ten round cycles) until the negedge on which out_ready is seen high.
   bit           m_busy = 1'b0;
   int           m_acc  = 0;
   int           ncnt   = 0;
   int           n_rise = 0;
   logic         prev_ov = 1'b0;
   logic [127:0] m_ct, m_lk;

   always @(negedge clk) begin
      logic [127:0] e_ct;
      logic         e_ov, e_ir;
      ncnt++;
      if (reset)                   begin e_ir = 1'b0; e_ov = 1'b0; e_ct = '0;   end
      else if (!m_busy)            begin e_ir = 1'b1; e_ov = 1'b0; e_ct = '0;   end
      else if (ncnt - m_acc < 11)  begin e_ir = 1'b0; e_ov = 1'b0; e_ct = '0;   end
      else                         begin e_ir = 1'b0; e_ov = 1'b1; e_ct = m_ct; end
      check("mon_in_ready",   {127'b0, in_ready},  {127'b0, e_ir});
      check("mon_out_valid",  {127'b0, out_valid}, {127'b0, e_ov});
      check("mon_ciphertext", ciphertext, e_ct);
`ifdef AES_ENC_LAST_KEY_OUT_EN
      if (reset)     check("mon_last_key_reset", last_key, '0);
      else if (e_ov) check("mon_last_key", last_key, m_lk);
`endif
      if (out_valid && !prev_ov) n_rise++;
      prev_ov = out_valid;
      if (reset)
         m_busy = 1'b0;
      else if (!m_busy) begin
         if (in_valid) begin
            m_busy = 1'b1;
            m_acc  = ncnt;
            m_ct   = aes_model(plaintext, key, m_lk);
         end
      end else if (ncnt - m_acc >= 11 && out_ready)
         m_busy = 1'b0;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_block(input logic [127:0] pt, input logic [127:0] k, output int acc);
      int g = 0;
      plaintext = pt;
      key       = k;
      in_valid  = 1'b1;
      while (!in_ready && g < 40) begin
         tick();
         g++;
      end
      check("send_in_ready", {127'b0, in_ready}, 128'd1);
      tick();
      acc      = edge_cnt;
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int g = 0;
      while (!out_valid && g < 40) begin
         tick();
         g++;
      end
      check("wait_out_valid", {127'b0, out_valid}, 128'd1);
   endtask

   initial begin
      logic [127:0] ct, lk, held, ct1;
      int acc, acc1, acc2, rise0;

      build_sbox();
      ct = aes_model(PT_B, KEY_B, lk);
      check("model_b_ct", ct, CT_B);
      check("model_b_lk", lk, LK_B);
      ct = aes_model(PT_C, KEY_C, lk);
      check("model_c_ct", ct, CT_C);
      check("model_c_lk", lk, LK_C);

      // Reset state
      repeat (3) tick();
      check("rst_in_ready",   {127'b0, in_ready},  '0);
      check("rst_out_valid",  {127'b0, out_valid}, '0);
      check("rst_ciphertext", ciphertext, '0);
`ifdef AES_ENC_LAST_KEY_OUT_EN
      check("rst_last_key", last_key, '0);
`endif
      reset = 1'b0;
      tick();
      check("idle_in_ready", {127'b0, in_ready}, 128'd1);

      // App. B: latency, result, then 20 cycles of backpressure
      send_block(PT_B, KEY_B, acc);
      wait_out();
      check("b_latency", 128'(edge_cnt - acc), 128'd10);
      check("b_ct", ciphertext, CT_B);
`ifdef AES_ENC_LAST_KEY_OUT_EN
      check("b_last_key", last_key, LK_B);
`endif
      held = ciphertext;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("bp_ct_stable", ciphertext, held);
         check("bp_in_ready",  {127'b0, in_ready},  '0);
         check("bp_out_valid", {127'b0, out_valid}, 128'd1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_release_in_ready",  {127'b0, in_ready},  128'd1);
      check("bp_release_out_valid", {127'b0, out_valid}, '0);

      // Busy input ignored: other blocks offered during rounds 3 and 7
      rise0 = n_rise;
      send_block(PT_B, KEY_B, acc);
      while (edge_cnt - acc < 2) tick();
      plaintext = PT_C; key = KEY_C; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      while (edge_cnt - acc < 6) tick();
      plaintext = 128'hdeadbeef00000000cafef00d12345678; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out();
      check("busy_ct", ciphertext, CT_B);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      repeat (15) tick();
      check("busy_single_result", 128'(n_rise - rise0), 128'd1);

      // Reset in the middle of round 5, then App. C.1
      send_block(PT_B, KEY_B, acc);
      while (edge_cnt - acc < 4) tick();
      reset = 1'b1;
      #1;
      check("midrst_out_valid",  {127'b0, out_valid}, '0);
      check("midrst_ciphertext", ciphertext, '0);
      check("midrst_in_ready",   {127'b0, in_ready},  '0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("midrst_idle_in_ready", {127'b0, in_ready}, 128'd1);
      send_block(PT_C, KEY_C, acc);
      wait_out();
      check("c_latency", 128'(edge_cnt - acc), 128'd10);
      check("c_ct", ciphertext, CT_C);
`ifdef AES_ENC_LAST_KEY_OUT_EN
      check("c_last_key", last_key, LK_C);
`endif
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();

      // Back-to-back with out_ready tied high: B then C.1
      out_ready = 1'b1;
      send_block(PT_B, KEY_B, acc1);
      plaintext = PT_C; key = KEY_C; in_valid = 1'b1;
      acc2 = -1;
      ct1  = '0;
      for (int g = 0; g < 30 && acc2 < 0; g++) begin
         if (out_valid) ct1 = ciphertext;
         if (in_ready) begin
            tick();
            acc2 = edge_cnt;
         end else
            tick();
      end
      in_valid = 1'b0;
      check("b2b_spacing", 128'(acc2 - acc1), 128'd12);
      check("b2b_first_ct", ct1, CT_B);
      wait_out();
      check("b2b_second_ct", ciphertext, CT_C);
`ifdef AES_ENC_LAST_KEY_OUT_EN
      check("b2b_second_last_key", last_key, LK_C);
`endif
      tick();
      check("b2b_done_in_ready", {127'b0, in_ready}, 128'd1);
      out_ready = 1'b0;
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
